matmul_control_unit: RTL and testbench

MATMUL_CONTROL_UNIT -- requirements
Module: matmul_control_unit

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_index_counter.sv | 77 +++++++
 rtl/matmul_control_unit.sv | 164 ++++++++++++++++
 tb/tb_matmul_control_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply control unit: FSM state
// encoding, default matrix dimension and width helpers.
package mm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mm_state_e;

   localparam int MM_DEFAULT_N = 4;

   // Width of a row-major address into an n x n matrix.
   function automatic int mm_addr_width(input int n);
      return (n * n <= 2) ? 1 : $clog2(n * n);
   endfunction

   // Width of one loop index counting 0..n-1.
   function automatic int mm_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Nested i/j/k loop counter for the matrix multiply: k is the innermost
// index, then j, then i. Advances one step per enabled cycle and wraps to
// all-zero after the last element.
module mm_index_counter
   import mm_pkg::*;
#(
   parameter int N  = MM_DEFAULT_N,
   parameter int CW = mm_cnt_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          advance_i,
   output logic [CW-1:0] i_o,
   output logic [CW-1:0] j_o,
   output logic [CW-1:0] k_o,
   output logic          last_k_o,
   output logic          last_elem_o
);

   localparam logic [CW-1:0] IDX_MAX = CW'(N - 1);

   logic [CW-1:0] i_q, i_d;
   logic [CW-1:0] j_q, j_d;
   logic [CW-1:0] k_q, k_d;
   logic          last_k;
   logic          last_j;
   logic          last_i;

   assign last_k = (k_q == IDX_MAX);
   assign last_j = (j_q == IDX_MAX);
   assign last_i = (i_q == IDX_MAX);

   // Next-index logic: k rolls into j, j rolls into i.
   always_comb begin
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      if (clear_i) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end else if (advance_i) begin
         if (last_k) begin
            k_d = '0;
            if (last_j) begin
               j_d = '0;
               i_d = last_i ? '0 : i_q + CW'(1);
            end else begin
               j_d = j_q + CW'(1);
            end
         end else begin
            k_d = k_q + CW'(1);
         end
      end
   end

   // Index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
      end
   end

   assign i_o         = i_q;
   assign j_o         = j_q;
   assign k_o         = k_q;
   assign last_k_o    = last_k;
   assign last_elem_o = last_k & last_j & last_i;

endmodule

// File: rtl/matmul_control_unit.sv
// Control unit for an N x N matrix multiply C = A x B. Issues one A/B read
// per cycle in i/j/k order and drives the accumulate datapath through a
// two-stage enable/address pipeline (memory-data stage, write stage).
module matmul_control_unit
   import mm_pkg::*;
#(
   parameter int N          = MM_DEFAULT_N,
   parameter int ADDR_WIDTH = mm_addr_width(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  resultIsInvalid,
   output logic                  readEn_A,
   output logic                  readEn_B,
   output logic [ADDR_WIDTH-1:0] addr_A,
   output logic [ADDR_WIDTH-1:0] addr_B,
   output logic                  writeEn_C,
   output logic [ADDR_WIDTH-1:0] addr_C,
   output logic                  en_Mux,
   output logic                  en_PPReg,
   output logic                  en_FDReg,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CW = mm_cnt_width(N);

   mm_state_e state_q, state_d;
   logic      drain_q, drain_d;
   logic      error_q, error_d;
   logic      start_accept;

   logic [CW-1:0] idx_i, idx_j, idx_k;
   logic          last_k, last_elem;

   logic                  run_p0;
   logic [ADDR_WIDTH-1:0] addr_a_p0, addr_b_p0, addr_c_p0;

   logic                  vld_p1_q, vld_p1_d;
   logic                  mux_p1_q, mux_p1_d;
   logic                  fd_p1_q,  fd_p1_d;
   logic [ADDR_WIDTH-1:0] addrc_p1_q, addrc_p1_d;

   logic                  vld_p2_q, vld_p2_d;
   logic [ADDR_WIDTH-1:0] addrc_p2_q, addrc_p2_d;

   mm_index_counter #(
      .N  (N),
      .CW (CW)
   ) u_index (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (start_accept),
      .advance_i   (run_p0),
      .i_o         (idx_i),
      .j_o         (idx_j),
      .k_o         (idx_k),
      .last_k_o    (last_k),
      .last_elem_o (last_elem)
   );

   // ---- p0: read stage, one (i,j,k) read per RUN cycle ----
   assign run_p0    = (state_q == RUN);
   assign addr_a_p0 = run_p0 ? ADDR_WIDTH'(int'(idx_i) * N + int'(idx_k)) : '0;
   assign addr_b_p0 = run_p0 ? ADDR_WIDTH'(int'(idx_k) * N + int'(idx_j)) : '0;
   assign addr_c_p0 = ADDR_WIDTH'(int'(idx_i) * N + int'(idx_j));

   // Sequencing FSM and sticky overflow flag.
   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      error_d      = error_q;
      start_accept = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (last_elem) begin
               state_d = DRAIN;
               drain_d = 1'b0;
            end
         end
         DRAIN: begin
            // Two cycles let the last element reach the write stage.
            if (drain_q) begin
               state_d = DONE;
               drain_d = 1'b0;
            end else begin
               drain_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (start_accept) begin
         error_d = 1'b0;
      end else if (vld_p2_q && resultIsInvalid) begin
         error_d = 1'b1;
      end
   end

   // Next values for the enable/address pipeline.
   always_comb begin
      // ---- p1: memory data valid, accumulate controls ----
      vld_p1_d   = run_p0;
      mux_p1_d   = run_p0 && (idx_k != '0);
      fd_p1_d    = run_p0 && last_k;
      addrc_p1_d = (run_p0 && last_k) ? addr_c_p0 : '0;
      // ---- p2: final data ready, write strobe ----
      vld_p2_d   = fd_p1_q;
      addrc_p2_d = fd_p1_q ? addrc_p1_q : '0;
   end

   // Control state and pipeline registers; reset clears everything so an
   // aborted operation leaves no pending write or done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         drain_q    <= 1'b0;
         error_q    <= 1'b0;
         vld_p1_q   <= 1'b0;
         mux_p1_q   <= 1'b0;
         fd_p1_q    <= 1'b0;
         addrc_p1_q <= '0;
         vld_p2_q   <= 1'b0;
         addrc_p2_q <= '0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         error_q    <= error_d;
         vld_p1_q   <= vld_p1_d;
         mux_p1_q   <= mux_p1_d;
         fd_p1_q    <= fd_p1_d;
         addrc_p1_q <= addrc_p1_d;
         vld_p2_q   <= vld_p2_d;
         addrc_p2_q <= addrc_p2_d;
      end
   end

   assign readEn_A  = run_p0;
   assign readEn_B  = run_p0;
   assign addr_A    = addr_a_p0;
   assign addr_B    = addr_b_p0;
   assign en_PPReg  = vld_p1_q;
   assign en_Mux    = mux_p1_q;
   assign en_FDReg  = fd_p1_q;
   assign writeEn_C = vld_p2_q;
   assign addr_C    = addrc_p2_q;
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign error     = error_q;

endmodule

// File: tb/tb_matmul_control_unit.sv
// Bench for matmul_control_unit at N=2 with a behavioural datapath and
// memories attached, a cycle-level reference model and literal traces.
module tb_matmul_control_unit;

   localparam int N     = 2;
   localparam int AW    = 2;
   localparam int NCUBE = N * N * N;
   localparam int TRC   = 14;

   localparam int EXP_A   [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
   localparam int EXP_B   [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
   localparam int EXP_MUX [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   localparam int EXP_C   [4] = '{19, 22, 43, 50};

   logic          clk;
   logic          reset;
   logic          start;
   logic          resultIsInvalid;
   logic          readEn_A, readEn_B;
   logic [AW-1:0] addr_A, addr_B, addr_C;
   logic          writeEn_C;
   logic          en_Mux, en_PPReg, en_FDReg;
   logic          busy, done, error;

   matmul_control_unit #(.N(N)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .resultIsInvalid (resultIsInvalid),
      .readEn_A        (readEn_A),
      .readEn_B        (readEn_B),
      .addr_A          (addr_A),
      .addr_B          (addr_B),
      .writeEn_C       (writeEn_C),
      .addr_C          (addr_C),
      .en_Mux          (en_Mux),
      .en_PPReg        (en_PPReg),
      .en_FDReg        (en_FDReg),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Behavioural memories and datapath driven by the control outputs.
   int memA [4] = '{1, 2, 3, 4};
   int memB [4] = '{5, 6, 7, 8};
   int memC [4] = '{default: 0};
   int rdA = 0, rdB = 0, acc = 0, fdr = 0;

   always @(posedge clk) begin
      if (readEn_A) rdA <= memA[addr_A];
      if (readEn_B) rdB <= memB[addr_B];
      if (en_PPReg) acc <= (en_Mux ? acc : 0) + rdA * rdB;
      if (en_FDReg) fdr <= (en_Mux ? acc : 0) + rdA * rdB;
      if (writeEn_C) memC[addr_C] <= fdr;
   end

   // Reference model: cycle number since the accepted start.
   bit m_en  = 1'b0;
   bit m_act = 1'b0;
   bit m_err = 1'b0;
   int m_rel = 0;

   function automatic bit m_we();
      return m_act && m_rel >= 3 && m_rel <= NCUBE + 2 && ((m_rel - 3) % N) == N - 1;
   endfunction

   function automatic logic [31:0] pack_model();
      int t;
      logic rd = 1'b0, pp = 1'b0, mx = 1'b0, fdv = 1'b0, we = 1'b0, bs = 1'b0, dn = 1'b0;
      logic [AW-1:0] aA = '0, aB = '0, aC = '0;
      if (m_act) begin
         if (m_rel >= 1 && m_rel <= NCUBE) begin
            t  = m_rel - 1;
            rd = 1'b1;
            aA = AW'((t / (N * N)) * N + t % N);
            aB = AW'((t % N) * N + (t / N) % N);
         end
         if (m_rel >= 2 && m_rel <= NCUBE + 1) begin
            t   = m_rel - 2;
            pp  = 1'b1;
            mx  = (t % N) != 0;
            fdv = (t % N) == N - 1;
         end
         if (m_we()) begin
            we = 1'b1;
            aC = AW'((m_rel - 3) / N);
         end
         bs = (m_rel <= NCUBE + 2);
         dn = (m_rel == NCUBE + 3);
      end
      return {17'd0, rd, rd, aA, aB, pp, mx, fdv, we, aC, bs, dn, m_err};
   endfunction

   function automatic logic [31:0] pack_dut();
      return {17'd0, readEn_A, readEn_B, addr_A, addr_B, en_PPReg, en_Mux, en_FDReg,
              writeEn_C, addr_C, busy, done, error};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // One clock: advance the model on the edge, compare on the falling edge.
   task automatic tick();
      bit cur_we;
      logic [31:0] dv, mv;
      cur_we = m_we();
      @(posedge clk);
      if (reset) begin
         m_en  = 1'b1;
         m_act = 1'b0;
         m_err = 1'b0;
      end else if (m_en) begin
         if (cur_we && resultIsInvalid) m_err = 1'b1;
         if (!m_act) begin
            if (start) begin
               m_act = 1'b1;
               m_rel = 1;
               m_err = 1'b0;
            end
         end else begin
            m_rel++;
            if (m_rel > NCUBE + 3) m_act = 1'b0;
         end
      end
      @(negedge clk);
      if (m_en) begin
         dv = pack_dut();
         mv = pack_model();
         checks++;
         if (dv !== mv) begin
            failures++;
            $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, dv, mv);
         end
      end
   endtask

   int trA [16], trB [16], trMux [16], trWe [16], trC [16];
   int trDone [16], trBusy [16], trErr [16], trAny [16];

   task automatic record(input int c);
      trA[c]    = int'(addr_A);
      trB[c]    = int'(addr_B);
      trMux[c]  = int'(en_Mux);
      trWe[c]   = int'(writeEn_C);
      trC[c]    = int'(addr_C);
      trDone[c] = int'(done);
      trBusy[c] = int'(busy);
      trErr[c]  = int'(error);
      trAny[c]  = (pack_dut() != 32'd0) ? 1 : 0;
   endtask

   // Start at cycle 0, then drive per-cycle events (-1 = never).
   task automatic run_trace(input int rii_c, input int start_c, input int rst_c);
      start = 1'b1;
      resultIsInvalid = 1'b0;
      reset = 1'b0;
      tick();
      for (int c = 1; c <= TRC; c++) begin
         record(c);
         resultIsInvalid = (c == rii_c);
         start = (c == start_c);
         reset = (c == rst_c);
         tick();
      end
      start = 1'b0;
      resultIsInvalid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic check_std(input string tg);
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("%s addr_A c%0d", tg, c), trA[c], EXP_A[c-1]);
         chk($sformatf("%s addr_B c%0d", tg, c), trB[c], EXP_B[c-1]);
      end
      for (int c = 2; c <= 9; c++)
         chk($sformatf("%s en_Mux c%0d", tg, c), trMux[c], EXP_MUX[c-2]);
      for (int c = 1; c <= 12; c++) begin
         bit w;
         w = (c == 4) || (c == 6) || (c == 8) || (c == 10);
         chk($sformatf("%s writeEn_C c%0d", tg, c), trWe[c], w ? 1 : 0);
         if (w) chk($sformatf("%s addr_C c%0d", tg, c), trC[c], (c - 4) / 2);
         chk($sformatf("%s done c%0d", tg, c), trDone[c], (c == 11) ? 1 : 0);
         chk($sformatf("%s busy c%0d", tg, c), trBusy[c], (c >= 1 && c <= 10) ? 1 : 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      resultIsInvalid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset error", int'(error), 0);
      chk("reset readEn_A", int'(readEn_A), 0);
      chk("reset writeEn_C", int'(writeEn_C), 0);
      chk("reset done", int'(done), 0);

      // Plain run; overflow flag raised on a non-write cycle is ignored.
      run_trace(5, -1, -1);
      check_std("run1");
      for (int c = 1; c <= TRC; c++) chk($sformatf("run1 error c%0d", c), trErr[c], 0);
      for (int e = 0; e < 4; e++) chk($sformatf("datapath C[%0d]", e), memC[e], EXP_C[e]);
      tick();
      tick();

      // Overflow on the write at cycle 6 sets a sticky error.
      run_trace(6, -1, -1);
      check_std("run2");
      chk("run2 error c6", trErr[6], 0);
      for (int c = 7; c <= TRC; c++) chk($sformatf("run2 error c%0d", c), trErr[c], 1);
      tick();
      chk("error sticky in idle", int'(error), 1);

      // Start pulse during RUN is ignored; the accepted start cleared error.
      run_trace(-1, 3, -1);
      check_std("run3");
      chk("run3 error cleared c1", trErr[1], 0);

      // Overflow at cycle 4, then reset at cycle 5 aborts everything.
      run_trace(4, -1, 5);
      chk("run4 writeEn_C c4", trWe[4], 1);
      chk("run4 error c5", trErr[5], 1);
      for (int c = 6; c <= TRC; c++) chk($sformatf("run4 outputs zero c%0d", c), trAny[c], 0);

      // Fresh start after the abort restarts at address 0.
      run_trace(-1, -1, -1);
      check_std("run5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
